// File: rtl/seq_signed_multiplier_if.sv
// Handshake/data bundle for seq_signed_multiplier.
//   start, mode_signed, multiplicand, multiplier : requester -> multiplier
//   product, done, busy, sign                    : multiplier -> requester
interface seq_signed_multiplier_if #(
  parameter int WIDTH = 8
) ();
  logic                   start;
  logic                   mode_signed;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [2*WIDTH-1:0]     product;
  logic                   done;
  logic                   busy;
  logic                   sign;

  modport master (
    output start, mode_signed, multiplicand, multiplier,
    input  product, done, busy, sign
  );

  modport slave (
    input  start, mode_signed, multiplicand, multiplier,
    output product, done, busy, sign
  );
endinterface

// File: rtl/seq_signed_multiplier.sv
// Sequential shift-and-add multiplier, signed or unsigned operands.
// Operands are reduced to magnitudes at start, multiplied over WIDTH cycles,
// and the sign is re-applied on the final cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of seq_signed_multiplier_if
//          (start/mode_signed/multiplicand/multiplier in,
//           product/done/busy/sign out)
module seq_signed_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  seq_signed_multiplier_if.slave    bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               r_done;
  logic               r_busy;
  logic               r_sign;

  logic               w_load;
  logic               w_step;
  logic               w_finish;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  // Most-negative operand negates to itself, which read as unsigned is
  // exactly 2^(WIDTH-1): the correct magnitude with no special case.
  assign w_a_neg = bus.mode_signed & bus.multiplicand[WIDTH-1];
  assign w_b_neg = bus.mode_signed & bus.multiplier[WIDTH-1];
  assign w_mag_a = w_a_neg ? (~bus.multiplicand + WIDTH'(1)) : bus.multiplicand;
  assign w_mag_b = w_b_neg ? (~bus.multiplier + WIDTH'(1)) : bus.multiplier;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_RUN;
      S_RUN:   if (r_cnt == LAST_CNT) w_next_state = S_FIN;
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE:  w_load   = bus.start;
      S_RUN:   w_step   = 1'b1;
      S_FIN:   w_finish = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_sign    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
        r_mplier <= w_mag_b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_sign   <= w_a_neg ^ w_b_neg;
        r_busy   <= 1'b1;
      end else if (w_step) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
      end else if (w_finish) begin
        r_product <= r_sign ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
        r_busy    <= 1'b0;
      end
    end
  end

  assign bus.product = r_product;
  assign bus.done    = r_done;
  assign bus.busy    = r_busy;
  assign bus.sign    = r_sign;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
module tb_seq_signed_multiplier;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_signed_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_signed_multiplier #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] prod;
    logic        sgn;
  } exp_t;

  exp_t exp_q[$];
  int   done_cyc_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ndone = 0;
  int   cyc   = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        if (prev_done) chk("done_width", 32'(prev_done & bus.done), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("product", 32'(bus.product), 32'(e.prod));
          chk("sign", 32'(bus.sign), 32'(e.sgn));
        end
        done_cyc_q.push_back(cyc);
        ndone++;
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic scramble();
    bus.multiplicand = 8'($urandom);
    bus.multiplier   = 8'($urandom);
    bus.mode_signed  = 1'($urandom);
  endtask

  // Drive one start pulse; returns just after the accepting edge.
  task automatic issue(input logic ms, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] p, input logic s, input bit expect_done);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode_signed = ms;
    bus.multiplicand = a;
    bus.multiplier = b;
    e.prod = p;
    e.sgn = s;
    if (expect_done) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n;
    n = 0;
    while (ndone < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    if (ndone < target) chk("done_timeout", 32'(ndone), 32'(target));
  endtask

  task automatic op(input logic ms, input logic [7:0] a, input logic [7:0] b,
                    input logic [15:0] p, input logic s);
    int target;
    target = ndone + 1;
    issue(ms, a, b, p, s, 1'b1);
    wait_dones(target, 30);
  endtask

  initial begin
    int base;
    int target;
    bus.start = 1'b0;
    bus.mode_signed = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_product", 32'(bus.product), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sign", 32'(bus.sign), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Signed 7 x -3 with cycle-exact latency checks
    target = ndone + 1;
    issue(1'b1, 8'd7, 8'hFD, 16'hFFEB, 1'b1, 1'b1);
    chk("busy_e0", 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk("busy_run", 32'(bus.busy), 32'd1);
      chk("done_run", 32'(bus.done), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("done_e9", 32'(bus.done), 32'd1);
    chk("busy_e9", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    chk("done_e10", 32'(bus.done), 32'd0);
    chk("hold_product", 32'(bus.product), 32'hFFEB);
    wait_dones(target, 5);

    // Boundary operands and modes
    op(1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);
    op(1'b1, 8'h80, 8'h01, 16'hFF80, 1'b1);
    op(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    op(1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0);
    op(1'b0, 8'h80, 8'h02, 16'h0100, 1'b0);
    op(1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b0);

    // Zero result with negative sign; start during RUN is ignored
    target = ndone + 1;
    issue(1'b1, 8'd0, 8'hFB, 16'h0000, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.mode_signed = 1'b0;
    bus.multiplicand = 8'd3;
    bus.multiplier = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_dones(target, 20);
    repeat (15) @(posedge clk);
    chk("no_extra_done", 32'(ndone), 32'(target));

    // start held high: three back-to-back operations
    exp_q.push_back('{16'h001E, 1'b0});
    exp_q.push_back('{16'hFFFA, 1'b1});
    exp_q.push_back('{16'hD8F0, 1'b1});
    base = done_cyc_q.size();
    target = ndone + 3;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode_signed = 1'b0;
    bus.multiplicand = 8'd5;
    bus.multiplier = 8'd6;
    @(posedge clk);
    #1;
    bus.mode_signed = 1'b1;
    bus.multiplicand = 8'hFE;
    bus.multiplier = 8'd3;
    repeat (10) @(posedge clk);
    #1;
    bus.multiplicand = 8'd100;
    bus.multiplier = 8'h9C;
    repeat (10) @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_dones(target, 40);
    if (done_cyc_q.size() >= base + 3) begin
      chk("b2b_gap1", 32'(done_cyc_q[base+1] - done_cyc_q[base]), 32'd10);
      chk("b2b_gap2", 32'(done_cyc_q[base+2] - done_cyc_q[base+1]), 32'd10);
    end else begin
      chk("b2b_count", 32'(done_cyc_q.size() - base), 32'd3);
    end

    // Reset during RUN aborts without a done pulse
    target = ndone;
    issue(1'b1, 8'd9, 8'd9, 16'h0051, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_product", 32'(bus.product), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_sign", 32'(bus.sign), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    chk("abort_no_done", 32'(ndone), 32'(target));
    op(1'b1, 8'hFA, 8'd7, 16'hFFD6, 1'b1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
